// File: rtl/memory_bus_responder_if.sv
// Memory bus handshake between the core's bus initiator and the RAM responder.
// The initiator drives address/data/strobe; the responder returns data and status.
interface memory_bus_responder_if #(
    parameter int ADDRESS_SIZE = 15
);
    logic [ADDRESS_SIZE-1:0] address;
    logic [31:0]             writeData;
    logic                    writeEnable;
    logic                    enable;
    logic [31:0]             readData;
    logic                    ready;
    logic                    error;

    modport master (
        output address, writeData, writeEnable, enable,
        input  readData, ready, error
    );

    modport slave (
        input  address, writeData, writeEnable, enable,
        output readData, ready, error
    );
endinterface

// File: rtl/memory_bus_responder.sv
// Memory-side bus endpoint: owns a single-port word RAM and serves one read or
// write per enable/ready handshake, with an optional fixed number of wait states.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for enable; request fields are latched on acceptance
// WAIT    | counting down wait states before the RAM access
// ACCESS  | the next edge performs the latched read or write
// RESPOND | ready held high until the initiator drops enable
module memory_bus_responder #(
    parameter int ADDRESS_SIZE = 15,
    parameter int WORDS        = 2 ** ADDRESS_SIZE,
    parameter int WAIT_STATES  = 0
) (
    input logic                    clock,
    input logic                    reset,
    memory_bus_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESPOND} state_t;

    // Index width for the implemented depth; out-of-range addresses never reach the RAM.
    localparam int                    IW        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDRESS_SIZE:0] WORDS_L   = (ADDRESS_SIZE + 1)'(WORDS);
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              wait_cnt;
    logic [ADDRESS_SIZE-1:0] lat_addr;
    logic [31:0]             lat_data;
    logic                    lat_we;
    logic [31:0]             read_q;
    logic                    ready_q;
    logic                    error_q;
    logic                    in_range;
    logic [IW-1:0]           mem_idx;
    logic [31:0]             mem [WORDS];

    assign in_range = ({1'b0, lat_addr} < WORDS_L);
    assign mem_idx  = lat_addr[IW-1:0];

    assign bus.readData = read_q;
    assign bus.ready    = ready_q;
    assign bus.error    = error_q;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; the wait branch is skipped entirely when no wait states are configured.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.enable) state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (wait_cnt == 4'd1) state_next = ACCESS;
            ACCESS:  state_next = RESPOND;
            RESPOND: if (!bus.enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, wait counter and registered response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_we   <= 1'b0;
            read_q   <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        lat_addr <= bus.address;
                        lat_data <= bus.writeData;
                        lat_we   <= bus.writeEnable;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                ACCESS: begin
                    ready_q <= 1'b1;
                    error_q <= !in_range;
                    if (!lat_we) begin
                        read_q <= in_range ? mem[mem_idx] : 32'h0;
                    end
                end
                RESPOND: begin
                    if (!bus.enable) begin
                        ready_q <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM write port; a reset coinciding with the access edge suppresses the write.
    always_ff @(posedge clock) begin
        if (!reset && state == ACCESS && lat_we && in_range) begin
            mem[mem_idx] <= lat_data;
        end
    end
endmodule
